vdecode_stage: RTL and testbench
================================

Name: vdecode_stage

Overview:
- Registered, parametrised instruction-decode stage for the scalar/vector core. Successor to the purely combinational field decoder.
- Splits an instruction word into op, cond, RvD, RvS, RnD, RnSA, RnSB and Imm.
- Adds a valid/ready handshake, illegal-opcode detection, a RAW/WAW scoreboard over the scalar and vector register files, flush, and a saturating stall counter.
- Sits between fetch and the execute/issue logic.

Parameters:
- INSTR_W, 32, instruction width; bit 0 is the MSB (big-endian field order).
- REG_AW, 3, register-address width; each register file holds NREG = 2**REG_AW registers.
- DATA_W, 32, width of the extended immediate.
- OP_VALID_MASK, 16'hFFFF, bit k set means opcode k is legal.
- WR_MASK, 16'hFFFF, bit k set means opcode k writes RnD.
- IMM_MASK, 16'h0000, bit k set means opcode k uses Imm instead of RnSB.
- IMM_SIGNED, 1, 1 sign-extends Imm, 0 zero-extends it.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word is valid.
- in_ready  out  1  stage accepts the instruction word.
- in_instr  in  INSTR_W  instruction word.
- flush  in  1  discard the output slot and clear the scoreboard.
- wb_valid  in  1  writeback completes.
- wb_vec  in  1  writeback targets the vector file (0 = scalar file).
- wb_rn  in  REG_AW  writeback register number.
- out_valid  out  1  decoded slot is valid.
- out_ready  in  1  consumer takes the slot.
- out_op  out  4  opcode.
- out_cond  out  1  condition flag.
- out_rvd  out  1  destination is in the vector file.
- out_rvs  out  1  sources are in the vector file.
- out_rnd  out  REG_AW  destination register.
- out_rnsa  out  REG_AW  source A register.
- out_rnsb  out  REG_AW  source B register.
- out_imm  out  DATA_W  extended immediate.
- out_use_imm  out  1  Imm replaces RnSB.
- out_illegal  out  1  opcode not in OP_VALID_MASK.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Field positions, counted from bit 0:
  - op [0:3], cond [4], RvD [5], RvS [6].
  - RnD, RnSA, RnSB: consecutive REG_AW-bit fields starting at bit 7.
  - Imm: the remaining IMM_W = INSTR_W - 7 - 3*REG_AW least-significant bits (16 with default parameters), extended to DATA_W.
- Reset (rst_n low, asynchronous):
  - out_valid = 0; all out_* fields = 0; stall_cnt = 0; scoreboard cleared.
  - in_ready follows its equation (combinational).
- Scoreboard: two NREG-bit vectors, sb_s (scalar) and sb_v (vector); bit set = write pending.
- Hazard (combinational on in_instr; evaluated only when in_valid = 1 and op is legal):
  - RnSA is pending in the file selected by RvS, or
  - RnSB is pending in the file selected by RvS and the op is not in IMM_MASK, or
  - the op is in WR_MASK and RnD is pending in the file selected by RvD.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready):
  - The decoded word loads into the output slot on the next edge; out_valid = 1.
  - Latency is 1 cycle.
- Hold: if out_valid && !out_ready, all out_* stay stable. Back-to-back accepts sustain 1 instruction per cycle.
- Slot drains with no new accept: out_valid falls on the next edge.
- Scoreboard set: on accept of a legal op in WR_MASK, bit RnD in the file selected by RvD sets on the same edge.
- Scoreboard clear: wb_valid clears bit wb_rn in the file selected by wb_vec on the next edge.
  - There is no bypass: a hazard on that register persists during the wb_valid cycle itself.
  - Set and clear of the same bit on the same edge: set wins.
- Illegal op:
  - Accepted without a hazard check; out_illegal = 1; scoreboard untouched.
  - Fields are still decoded for debug.
- Flush (highest priority):
  - in_ready = 0 during the flush cycle.
  - Next edge: out_valid = 0 and both scoreboards cleared.
  - A wb_valid in the same cycle is ignored.
  - Flush is issued only after the backend has drained.
- stall_cnt increments in each cycle where in_valid && hazard && !flush, and saturates at 16'hFFFF.

Decomposition:
- Package vdecode_pkg:
  - Field-offset constants and the opcode enum.
  - A typedef struct for the decoded word: op, cond, rvd, rvs, rnd, rnsa, rnsb, imm, use_imm, illegal.
  - Function decode_fields(), shared with the testbench model.
- Sub-module vscoreboard (parametrised by NREG):
  - Holds both bit vectors.
  - Inputs: set, set_vec, set_rn, clr, clr_vec, clr_rn, flush.
  - Outputs: pend_s, pend_v.

Test Plan:
1. Reset, then in_instr = 32'b0000_1_0_1_000_011_010_0110000010000000 with in_valid = 1 and out_ready = 1 → next cycle: out_op = 0, cond = 1, rvd = 0, rvs = 1, rnd = 0, rnsa = 3, rnsb = 2, out_imm = 32'h00006080; sb_s[0] set.
2. RAW: accept an op writing scalar r5, then immediately an instruction reading scalar r5 → in_ready = 0 and stall_cnt counts up each cycle. Pulse wb_valid with wb_vec = 0, wb_rn = 5 → accept on the cycle after the pulse.
3. Backpressure: out_ready = 0 for 3 cycles while in_valid = 1 → out_* stable, in_ready = 0. out_ready rises → the next instruction appears 1 cycle later with no loss or duplication.
4. Illegal: OP_VALID_MASK = 16'h7FFF, op = 4'hF → out_illegal = 1, scoreboard unchanged, accepted even if its RnSA field names a pending register.
5. Same-edge set/clear of vector r2 (accept writing v2 while wb_valid clears v2) → sb_v[2] = 1 afterwards.
6. Flush with out_valid = 1 and three scoreboard bits set → next cycle: out_valid = 0, scoreboard = 0. Assert rst_n low mid-stream → outputs zero asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/vdecode_pkg.sv
// Shared decode definitions: field offsets, opcodes, the decoded-word layout and
// the field extractor used by the decode stage and by its reference model.
package vdecode_pkg;
  localparam int OP_POS   = 0;
  localparam int COND_POS = 4;
  localparam int RVD_POS  = 5;
  localparam int RVS_POS  = 6;
  localparam int RN_POS   = 7;
  localparam int MAX_W    = 64;
  localparam int MAX_AW   = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL,
    OP_ADDI, OP_SUBI, OP_LDI, OP_LD, OP_ST, OP_CMP, OP_BR, OP_SYS
  } opcode_e;

  typedef struct packed {
    opcode_e           op;
    logic              cond;
    logic              rvd;
    logic              rvs;
    logic [MAX_AW-1:0] rnd;
    logic [MAX_AW-1:0] rnsa;
    logic [MAX_AW-1:0] rnsb;
    logic [MAX_W-1:0]  imm;
    logic              use_imm;
    logic              illegal;
  } dec_t;

  // Bit 0 is the MSB, so a field at position pos sits (instr_w - pos - w) bits up.
  function automatic logic [MAX_W-1:0] field(input logic [MAX_W-1:0] instr, input int instr_w,
                                             input int pos, input int w);
    return (instr >> (instr_w - pos - w)) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic dec_t decode_fields(input logic [MAX_W-1:0] instr, input int instr_w,
                                         input int reg_aw, input int data_w,
                                         input logic [15:0] valid_mask,
                                         input logic [15:0] imm_mask, input bit imm_signed);
    dec_t             d;
    int               imm_w;
    logic [MAX_W-1:0] imask;
    logic [MAX_W-1:0] imm;
    imm_w  = instr_w - RN_POS - 3 * reg_aw;
    imask  = (64'd1 << imm_w) - 64'd1;
    d.op   = opcode_e'(4'(field(instr, instr_w, OP_POS, 4)));
    d.cond = 1'(field(instr, instr_w, COND_POS, 1));
    d.rvd  = 1'(field(instr, instr_w, RVD_POS, 1));
    d.rvs  = 1'(field(instr, instr_w, RVS_POS, 1));
    d.rnd  = MAX_AW'(field(instr, instr_w, RN_POS, reg_aw));
    d.rnsa = MAX_AW'(field(instr, instr_w, RN_POS + reg_aw, reg_aw));
    d.rnsb = MAX_AW'(field(instr, instr_w, RN_POS + 2 * reg_aw, reg_aw));
    imm    = instr & imask;
    if (imm_signed && ((imm >> (imm_w - 1)) & 64'd1) != 64'd0)
      imm = imm | ~imask;
    if (data_w < MAX_W)
      imm = imm & ((64'd1 << data_w) - 64'd1);
    d.imm     = imm;
    d.use_imm = imm_mask[d.op];
    d.illegal = !valid_mask[d.op];
    return d;
  endfunction
endpackage

// File: rtl/vscoreboard.sv
// Pending-write scoreboard for the scalar and vector register files; a same-edge
// set and clear of one bit leaves it set, flush empties both files.
module vscoreboard #(
  parameter int NREG = 8,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic            set_vec,
  input  logic [AW-1:0]   set_rn,
  input  logic            clr,
  input  logic            clr_vec,
  input  logic [AW-1:0]   clr_rn,
  input  logic            flush,
  output logic [NREG-1:0] pend_s,
  output logic [NREG-1:0] pend_v
);
  logic [NREG-1:0] set_s, set_v, clr_s, clr_v;

  always_comb begin
    set_s = '0;
    set_v = '0;
    clr_s = '0;
    clr_v = '0;
    if (set) begin
      if (set_vec) set_v[set_rn] = 1'b1;
      else         set_s[set_rn] = 1'b1;
    end
    if (clr) begin
      if (clr_vec) clr_v[clr_rn] = 1'b1;
      else         clr_s[clr_rn] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_s <= '0;
      pend_v <= '0;
    end else if (flush) begin
      pend_s <= '0;
      pend_v <= '0;
    end else begin
      pend_s <= (pend_s & ~clr_s) | set_s;
      pend_v <= (pend_v & ~clr_v) | set_v;
    end
  end
endmodule

// File: rtl/vdecode_stage.sv
// Registered instruction-decode stage: field split, illegal-op flag, RAW/WAW
// hazard stall against the register scoreboards, flush and stall counting.
module vdecode_stage
  import vdecode_pkg::*;
#(
  parameter int          INSTR_W       = 32,
  parameter int          REG_AW        = 3,
  parameter int          DATA_W        = 32,
  parameter logic [15:0] OP_VALID_MASK = 16'hFFFF,
  parameter logic [15:0] WR_MASK       = 16'hFFFF,
  parameter logic [15:0] IMM_MASK      = 16'h0000,
  parameter bit          IMM_SIGNED    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic               wb_vec,
  input  logic [REG_AW-1:0]  wb_rn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_op,
  output logic               out_cond,
  output logic               out_rvd,
  output logic               out_rvs,
  output logic [REG_AW-1:0]  out_rnd,
  output logic [REG_AW-1:0]  out_rnsa,
  output logic [REG_AW-1:0]  out_rnsb,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_use_imm,
  output logic               out_illegal,
  output logic [15:0]        stall_cnt
);
  localparam int NREG = 2 ** REG_AW;

  dec_t              dec;
  logic [REG_AW-1:0] rnd, rnsa, rnsb;
  logic [NREG-1:0]   pend_s, pend_v, src_pend, dst_pend;
  logic              hazard, accept, writes, unused_bits;

  assign dec  = decode_fields(MAX_W'(in_instr), INSTR_W, REG_AW, DATA_W,
                              OP_VALID_MASK, IMM_MASK, IMM_SIGNED);
  assign rnd  = dec.rnd[REG_AW-1:0];
  assign rnsa = dec.rnsa[REG_AW-1:0];
  assign rnsb = dec.rnsb[REG_AW-1:0];
  assign unused_bits = ^{dec.rnd[MAX_AW-1:REG_AW], dec.rnsa[MAX_AW-1:REG_AW],
                         dec.rnsb[MAX_AW-1:REG_AW], dec.imm[MAX_W-1:DATA_W]};
  assign writes = WR_MASK[dec.op] && !dec.illegal;

  // Illegal ops never stall: they carry no real operands to wait for.
  always_comb begin
    src_pend = dec.rvs ? pend_v : pend_s;
    dst_pend = dec.rvd ? pend_v : pend_s;
    hazard   = 1'b0;
    if (in_valid && !dec.illegal)
      hazard = src_pend[rnsa] || (src_pend[rnsb] && !dec.use_imm) || (writes && dst_pend[rnd]);
  end

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  vscoreboard #(.NREG(NREG)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (accept && writes),
    .set_vec (dec.rvd),
    .set_rn  (rnd),
    .clr     (wb_valid),
    .clr_vec (wb_vec),
    .clr_rn  (wb_rn),
    .flush   (flush),
    .pend_s  (pend_s),
    .pend_v  (pend_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_cond    <= 1'b0;
      out_rvd     <= 1'b0;
      out_rvs     <= 1'b0;
      out_rnd     <= '0;
      out_rnsa    <= '0;
      out_rnsb    <= '0;
      out_imm     <= '0;
      out_use_imm <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_op      <= dec.op;
      out_cond    <= dec.cond;
      out_rvd     <= dec.rvd;
      out_rvs     <= dec.rvs;
      out_rnd     <= rnd;
      out_rnsa    <= rnsa;
      out_rnsb    <= rnsb;
      out_imm     <= dec.imm[DATA_W-1:0];
      out_use_imm <= dec.use_imm;
      out_illegal <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hazard && !flush && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_vdecode_stage.sv
// Scoreboard bench for vdecode_stage: directed scenarios then random traffic,
// checked against a queue/array model of the slot, scoreboards and stall count.
module tb_vdecode_stage;
  import vdecode_pkg::*;

  localparam logic [15:0] VMASK = 16'h7FFF;
  localparam logic [15:0] WMASK = 16'h3FFF;
  localparam logic [15:0] IMASK = 16'h0F00;

  logic        clk, rst_n, in_valid, in_ready, flush, wb_valid, wb_vec;
  logic [31:0] in_instr;
  logic [2:0]  wb_rn, out_rnd, out_rnsa, out_rnsb;
  logic        out_valid, out_ready, out_cond, out_rvd, out_rvs, out_use_imm, out_illegal;
  logic [3:0]  out_op;
  logic [31:0] out_imm;
  logic [15:0] stall_cnt;

  int   total = 0;
  int   bad = 0;
  int   stall_m = 0;
  dec_t exp_q[$];
  bit   pend[2][8];
  bit   r;
  int   s0;

  vdecode_stage #(
    .INSTR_W(32), .REG_AW(3), .DATA_W(32), .OP_VALID_MASK(VMASK),
    .WR_MASK(WMASK), .IMM_MASK(IMASK), .IMM_SIGNED(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .wb_valid(wb_valid), .wb_vec(wb_vec), .wb_rn(wb_rn),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_cond(out_cond),
    .out_rvd(out_rvd), .out_rvs(out_rvs), .out_rnd(out_rnd), .out_rnsa(out_rnsa),
    .out_rnsb(out_rnsb), .out_imm(out_imm), .out_use_imm(out_use_imm),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic c, input logic rd,
                                     input logic rs, input logic [2:0] d, input logic [2:0] a,
                                     input logic [2:0] b, input logic [15:0] imm);
    return {op, c, rd, rs, d, a, b, imm};
  endfunction

  function automatic bit model_hazard(input logic [31:0] ins);
    dec_t d;
    d = decode_fields(64'(ins), 32, 3, 32, VMASK, IMASK, 1'b1);
    if (!VMASK[ins[31:28]]) return 1'b0;
    if (pend[d.rvs][d.rnsa[2:0]]) return 1'b1;
    if (!IMASK[ins[31:28]] && pend[d.rvs][d.rnsb[2:0]]) return 1'b1;
    if (WMASK[ins[31:28]] && pend[d.rvd][d.rnd[2:0]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearModel();
    exp_q.delete();
    foreach (pend[f, n]) pend[f][n] = 1'b0;
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit ordy,
                               input bit wbv, input bit wbvec, input logic [2:0] wbrn,
                               input bit fl, output bit rdy);
    bit   hz, exp_rdy;
    dec_t d;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_valid = wbv; wb_vec = wbvec; wb_rn = wbrn; flush = fl;
    #1;
    hz      = v && model_hazard(ins);
    exp_rdy = (exp_q.size() == 0 || ordy) && !hz && !fl;
    rdy     = in_ready;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    d = decode_fields(64'(ins), 32, 3, 32, VMASK, IMASK, 1'b1);
    @(posedge clk);
    if (fl) begin
      clearModel();
    end else begin
      if (wbv) pend[wbvec][wbrn] = 1'b0;
      if (v && exp_rdy) begin
        exp_q.push_back(d);
        if (VMASK[ins[31:28]] && WMASK[ins[31:28]]) pend[d.rvd][d.rnd[2:0]] = 1'b1;
      end
    end
    if (hz && !fl && stall_m < 65535) stall_m++;
  endtask

  task automatic asyncReset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", 64'(out_valid), 64'd0);
    checkOutput("areset_stall", 64'(stall_cnt), 64'd0);
    checkOutput("areset_fields", {14'd0, out_op, out_cond, out_rvd, out_rvs, out_rnd, out_rnsa,
                                  out_rnsb, out_imm, out_use_imm, out_illegal}, 64'd0);
    clearModel();
    stall_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented slot with the head of the expected queue.
  initial begin
    dec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          checkOutput("out_fields",
            {14'd0, out_op, out_cond, out_rvd, out_rvs, out_rnd, out_rnsa, out_rnsb,
             out_imm, out_use_imm, out_illegal},
            {14'd0, e.op, e.cond, e.rvd, e.rvs, e.rnd[2:0], e.rnsa[2:0], e.rnsb[2:0],
             e.imm[31:0], e.use_imm, e.illegal});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    flush = 1'b0; wb_valid = 1'b0; wb_vec = 1'b0; wb_rn = '0;
    clearModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_stall", 64'(stall_cnt), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_imm", 64'(out_imm), 64'd0);

    // Field split of a known word, then its destination s0 blocks a reader.
    applyStimulus(1, 32'b0000_1_0_1_000_011_010_0110000010000000, 1, 0, 0, 0, 0, r);
    #1;
    checkOutput("t1_fields", {14'd0, out_op, out_cond, out_rvd, out_rvs, out_rnd, out_rnsa,
                              out_rnsb, out_imm, out_use_imm, out_illegal},
                {14'd0, 4'h0, 1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 3'd2, 32'h00006080, 1'b0, 1'b0});
    applyStimulus(1, mk(14, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t1_sb_s0", 64'(r), 64'd0);
    applyStimulus(1, mk(14, 0, 0, 0, 0, 0, 1, 0), 1, 1, 0, 0, 0, r);
    applyStimulus(1, mk(14, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t1_after_wb", 64'(r), 64'd1);

    // RAW on scalar r5, released the cycle after the writeback pulse.
    applyStimulus(1, mk(1, 0, 0, 0, 5, 1, 2, 0), 1, 0, 0, 0, 0, r);
    #1 s0 = int'(stall_cnt);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(14, 0, 0, 0, 6, 5, 1, 0), 1, 0, 0, 0, 0, r);
      checkOutput("t2_raw_stall", 64'(r), 64'd0);
    end
    applyStimulus(1, mk(14, 0, 0, 0, 6, 5, 1, 0), 1, 1, 0, 5, 0, r);
    checkOutput("t2_no_bypass", 64'(r), 64'd0);
    applyStimulus(1, mk(14, 0, 0, 0, 6, 5, 1, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t2_release", 64'(r), 64'd1);
    #1 checkOutput("t2_stall_delta", 64'(int'(stall_cnt) - s0), 64'd4);

    // Backpressure: slot A held three cycles, then B (negative immediate) follows.
    applyStimulus(1, mk(14, 0, 0, 0, 0, 1, 2, 16'h1111), 1, 0, 0, 0, 0, r);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, mk(9, 0, 1, 0, 6, 1, 2, 16'h8001), 0, 0, 0, 0, 0, r);
      checkOutput("t3_hold_ready", 64'(r), 64'd0);
    end
    applyStimulus(1, mk(9, 0, 1, 0, 6, 1, 2, 16'h8001), 1, 0, 0, 0, 0, r);
    #1;
    checkOutput("t3_b_imm", 64'(out_imm), 64'hFFFF8001);
    checkOutput("t3_b_use_imm", 64'(out_use_imm), 64'd1);
    applyStimulus(0, 0, 1, 1, 1, 6, 0, r);

    // Illegal op ignores a pending source and never marks its destination.
    applyStimulus(1, mk(1, 0, 0, 0, 4, 0, 1, 0), 1, 0, 0, 0, 0, r);
    applyStimulus(1, mk(15, 0, 0, 0, 7, 4, 4, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t4_illegal_accept", 64'(r), 64'd1);
    #1 checkOutput("t4_illegal_flag", 64'(out_illegal), 64'd1);
    applyStimulus(1, mk(14, 0, 0, 0, 0, 7, 7, 0), 1, 1, 0, 4, 0, r);
    checkOutput("t4_sb_untouched", 64'(r), 64'd1);

    // Same-edge set and clear of v2 leaves it pending.
    applyStimulus(1, mk(1, 0, 1, 0, 2, 0, 1, 0), 1, 1, 1, 2, 0, r);
    applyStimulus(1, mk(14, 0, 0, 1, 0, 2, 3, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t5_set_wins", 64'(r), 64'd0);
    applyStimulus(0, 0, 1, 1, 1, 2, 0, r);

    // Flush with a held slot and s1, s3, v5 pending.
    applyStimulus(1, mk(1, 0, 0, 0, 1, 0, 2, 0), 1, 0, 0, 0, 0, r);
    applyStimulus(1, mk(1, 0, 0, 0, 3, 0, 2, 0), 1, 0, 0, 0, 0, r);
    applyStimulus(1, mk(1, 0, 1, 0, 5, 0, 2, 0), 1, 0, 0, 0, 0, r);
    applyStimulus(1, mk(14, 0, 0, 0, 0, 1, 3, 0), 0, 0, 0, 0, 1, r);
    checkOutput("t6_flush_ready", 64'(r), 64'd0);
    #1 checkOutput("t6_flush_valid", 64'(out_valid), 64'd0);
    applyStimulus(1, mk(14, 0, 0, 0, 0, 1, 3, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t6_sb_s_clear", 64'(r), 64'd1);
    applyStimulus(1, mk(14, 0, 0, 1, 0, 5, 5, 0), 1, 0, 0, 0, 0, r);
    checkOutput("t6_sb_v_clear", 64'(r), 64'd1);

    applyStimulus(1, mk(14, 1, 0, 0, 0, 0, 0, 16'h1234), 1, 0, 0, 0, 0, r);
    asyncReset();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, 1'($urandom), 3'($urandom),
                    $urandom_range(0, 49) == 0, r);
    end
    repeat (3) applyStimulus(0, 0, 1, 0, 0, 0, 0, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
